// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a program-load write port
// and an optional zero-fill sweep after reset.
module instr_fetch_mem #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     DEPTH          = 32,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [XLEN-1:0] NOP_WORD       = XLEN'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [XLEN-1:0]          resp_instr,
  output logic [1:0]               resp_fault,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [DEPTH];

  logic        accept;
  logic [29:0] word_idx;
  logic        misaligned;
  logic        out_of_range;

  assign accept       = req_valid && req_ready;
  assign word_idx     = req_addr[31:2];
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = word_idx >= 30'(DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush outranks every handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: begin
        if (clr_idx == AW'(DEPTH - 1)) state_nxt = S_IDLE;
      end
      S_IDLE, S_RESP: begin
        if (flush)                              state_nxt = S_IDLE;
        else if (accept)                        state_nxt = S_RESP;
        else if (state == S_RESP && resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      S_CLEAR: busy = 1'b1;
      S_IDLE:  req_ready = !flush && !reset;
      S_RESP: begin
        resp_valid = 1'b1;
        req_ready  = !flush && !reset && resp_ready;
      end
      default: ;
    endcase
  end

  // Zero-fill sweep index
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
    end
  end

  // Storage: the sweep owns the write port while clearing
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (prog_we) begin
        mem[prog_addr] <= prog_data;
      end
    end
  end

  // Response payload; the read sees pre-write contents on a same-index write
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_instr <= '0;
      resp_fault <= FAULT_NONE;
    end else if (accept) begin
      if (misaligned) begin
        resp_instr <= NOP_WORD;
        resp_fault <= FAULT_ALIGN;
      end else if (out_of_range) begin
        resp_instr <= NOP_WORD;
        resp_fault <= FAULT_RANGE;
      end else begin
        resp_instr <= mem[word_idx[AW-1:0]];
        resp_fault <= FAULT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a behavioural model.
module tb_instr_fetch_mem;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_instr;
  logic [1:0]    resp_fault;
  logic          flush;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  instr_fetch_mem #(
    .XLEN(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_fault(resp_fault),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: pending-response flag, words left to clear, memory image
  logic [31:0] m_mem [DEPTH];
  int          clear_left = 0;
  bit          m_valid    = 1'b0;
  logic [31:0] m_instr    = '0;
  logic [1:0]  m_fault    = '0;
  bit          started    = 1'b0;

  function automatic bit model_ready();
    return !reset && !flush && clear_left == 0 && (!m_valid || resp_ready);
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    acc = req_valid && model_ready();
    if (reset) begin
      m_valid    = 1'b0;
      m_instr    = '0;
      m_fault    = 2'b00;
      clear_left = DEPTH;
      started    = 1'b1;
    end else if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        if (req_addr[1:0] != 2'b00) begin
          m_fault = 2'b01;
          m_instr = NOP;
        end else if (req_addr[31:2] >= 30'(DEPTH)) begin
          m_fault = 2'b10;
          m_instr = NOP;
        end else begin
          m_fault = 2'b00;
          m_instr = m_mem[req_addr[AW+1:2]];
        end
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      if (prog_we) m_mem[prog_addr] = prog_data;
    end
  end

  // Per-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (started) begin
      check("busy", 32'(busy), 32'(clear_left > 0));
      check("req_ready", 32'(req_ready), 32'(model_ready()));
      check("resp_valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
        check("resp_instr", resp_instr, m_instr);
        check("resp_fault", 32'(resp_fault), 32'(m_fault));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] instr, input logic [1:0] fault);
    check({name, "_valid"}, 32'(resp_valid), 32'd1);
    check({name, "_instr"}, resp_instr, instr);
    check({name, "_fault"}, 32'(resp_fault), 32'(fault));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    step();
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_instr", resp_instr, 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    step();
    reset = 1'b0;

    // Sweep length, with a request held off the whole time
    req_valid = 1'b1;
    req_addr  = 32'h0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check("ready_in_clear", 32'(req_ready), 32'd0);
      n++;
      step();
    end
    check("clear_cycles", 32'(n), 32'd32);
    step();
    req_valid = 1'b0;
    lit("cleared_word0", 32'h0, 2'b00);

    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 32'h001080B3;
    step();
    prog_we = 1'b0;
    fetch(32'h0);  lit("prog_word0", 32'h001080B3, 2'b00);
    fetch(32'h2);  lit("misaligned", NOP, 2'b01);
    fetch(32'h80); lit("out_of_range", NOP, 2'b10);
    fetch(32'h82); lit("fault_prec", NOP, 2'b01);
    fetch(32'h7C); lit("last_word", 32'h0, 2'b00);

    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 32'h00208133;
    step();
    prog_addr = 5'd2; prog_data = 32'h003101B3;
    step();
    prog_we = 1'b0;

    // Stall the consumer, then stream two fetches back to back
    resp_ready = 1'b0;
    fetch(32'h0);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    for (int i = 0; i < 3; i++) begin
      lit("stall_hold", 32'h001080B3, 2'b00);
      check("stall_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    lit("b2b_first", 32'h00208133, 2'b00);
    req_addr = 32'h8;
    step();
    lit("b2b_second", 32'h003101B3, 2'b00);
    req_valid = 1'b0;
    step();
    check("b2b_drain", 32'(resp_valid), 32'd0);

    // Flush against a pending response and a live request
    resp_ready = 1'b0;
    fetch(32'h0);
    req_valid = 1'b1; req_addr = 32'h4; flush = 1'b1;
    check("flush_ready", 32'(req_ready), 32'd0);
    step();
    check("flush_valid", 32'(resp_valid), 32'd0);
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    step();
    check("flush_no_accept", 32'(resp_valid), 32'd0);
    fetch(32'h0); lit("flush_mem_kept", 32'h001080B3, 2'b00);

    // Read and write of the same index in one cycle
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    prog_we = 1'b0; req_valid = 1'b0;
    lit("rw_old", 32'h00208133, 2'b00);
    fetch(32'h4); lit("rw_new", 32'hDEADBEEF, 2'b00);

    // Reset while a response is pending
    resp_ready = 1'b0;
    fetch(32'h4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    resp_ready = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("midrst_clear_cycles", 32'(n), 32'd32);
    fetch(32'h4); lit("midrst_cleared", 32'h0, 2'b00);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      req_valid  = $urandom_range(0, 1) != 0;
      resp_ready = $urandom_range(0, 3) != 0;
      prog_we    = $urandom_range(0, 3) == 0;
      prog_addr  = AW'($urandom_range(0, DEPTH - 1));
      prog_data  = $urandom;
      case ($urandom_range(0, 5))
        0: begin
          req_addr = $urandom;
          if (req_addr[1:0] == 2'b00) req_addr[0] = 1'b1;
        end
        1: req_addr = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
        2: req_addr = {$urandom_range(1, 3) != 0 ? 2'b11 : 2'b10, 28'($urandom), 2'b00};
        default: req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      step();
    end
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; prog_we = 1'b0; resp_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
